// File: rtl/pipelined_barrel_rotator_pkg.sv
// Shared definitions for the pipelined barrel rotator: default width and rotation direction
// encoding.
package pipelined_barrel_rotator_pkg;

    localparam int unsigned DefaultN = 8;

    typedef enum logic {
        DirLeft  = 1'b0,
        DirRight = 1'b1
    } dir_e;

endpackage

// File: rtl/pipelined_barrel_rotator_if.sv
// Producer-side and consumer-side valid/ready streams of the rotator. The master modport is
// the environment; the slave modport is the rotator.
interface pipelined_barrel_rotator_if
    import pipelined_barrel_rotator_pkg::*;
#(
    parameter int unsigned N = DefaultN
);
    localparam int unsigned SW = $clog2(N);

    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [SW-1:0] in_amt;
    logic          in_dir;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;

    modport master (
        output in_valid, in_data, in_amt, in_dir, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_dir, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/pipelined_barrel_rotator_stage.sv
// One rotator pipeline stage: conditionally rotates by 2^K and holds the word until the
// downstream stage (or consumer) takes it.
module rotator_stage
    import pipelined_barrel_rotator_pkg::*;
#(
    parameter int unsigned N = DefaultN,
    parameter int unsigned K = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   up_valid_i,
    input  logic                   up_dir_i,
    input  logic [$clog2(N)-1:0]   up_amt_i,
    input  logic [N-1:0]           up_data_i,
    output logic                   up_ready_o,
    output logic                   down_valid_o,
    output logic                   down_dir_o,
    output logic [$clog2(N)-1:0]   down_amt_o,
    output logic [N-1:0]           down_data_o,
    input  logic                   down_ready_i
);
    localparam int unsigned SW = $clog2(N);
    localparam int unsigned M  = 2 ** K;

    typedef struct packed {
        logic          valid;
        logic          dir;
        logic [SW-1:0] amt;
        logic [N-1:0]  data;
    } stage_t;

    stage_t stage_q, stage_d;
    logic   load;

    function automatic logic [N-1:0] rot_left(input logic [N-1:0] d);
        return {d[N-1-M:0], d[N-1:N-M]};
    endfunction

    function automatic logic [N-1:0] rot_right(input logic [N-1:0] d);
        return {d[M-1:0], d[N-1:M]};
    endfunction

    // A stage refills when empty or when its contents leave this cycle, so bubbles collapse.
    always_comb begin
        load    = !stage_q.valid || down_ready_i;
        stage_d = stage_q;
        if (load) begin
            stage_d.valid = up_valid_i;
            if (up_valid_i) begin
                stage_d.dir = up_dir_i;
                stage_d.amt = up_amt_i;
                if (up_amt_i[K]) begin
                    stage_d.data = (up_dir_i == DirRight) ? rot_right(up_data_i)
                                                          : rot_left(up_data_i);
                end else begin
                    stage_d.data = up_data_i;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign up_ready_o   = load;
    assign down_valid_o = stage_q.valid;
    assign down_dir_o   = stage_q.dir;
    assign down_amt_o   = stage_q.amt;
    assign down_data_o  = stage_q.data;

endmodule

// File: rtl/pipelined_barrel_rotator.sv
// Run-time configurable N-bit circular rotator built as a log2(N)-stage valid/ready pipeline.
module pipelined_barrel_rotator
    import pipelined_barrel_rotator_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic                       clk,
    input  logic                       rst_n,
    pipelined_barrel_rotator_if.slave  bus
);
    localparam int unsigned SW = $clog2(N);

    // Index 0 is the producer side; index k+1 is the output of stage k.
    logic [SW:0]         vld;
    logic [SW:0]         dir;
    logic [SW:0][SW-1:0] amt;
    logic [SW:0][N-1:0]  dat;
    logic [SW:0]         rdy;

    assign vld[0]  = bus.in_valid;
    assign dir[0]  = bus.in_dir;
    assign amt[0]  = bus.in_amt;
    assign dat[0]  = bus.in_data;
    assign rdy[SW] = bus.out_ready;

    for (genvar k = 0; k < SW; k++) begin : g_stage
        rotator_stage #(
            .N (N),
            .K (k)
        ) u_stage (
            .clk          (clk),
            .rst_n        (rst_n),
            .up_valid_i   (vld[k]),
            .up_dir_i     (dir[k]),
            .up_amt_i     (amt[k]),
            .up_data_i    (dat[k]),
            .up_ready_o   (rdy[k]),
            .down_valid_o (vld[k+1]),
            .down_dir_o   (dir[k+1]),
            .down_amt_o   (amt[k+1]),
            .down_data_o  (dat[k+1]),
            .down_ready_i (rdy[k+1])
        );
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld[SW];
    assign bus.out_data  = dat[SW];

    // The last stage's direction and amount have no consumer.
    logic unused_tail;
    assign unused_tail = ^{dir[SW], amt[SW]};

endmodule

// File: tb/tb_pipelined_barrel_rotator.sv
// Self-checking bench for pipelined_barrel_rotator (N = 8): directed vector table plus
// scoreboarded streaming, stall, random back-pressure and mid-stream reset sequences.
module tb_pipelined_barrel_rotator;

    localparam int unsigned N  = 8;
    localparam int unsigned SW = 3;

    typedef struct {
        logic [7:0] data;
        logic [2:0] amt;
        logic       dir;
        logic [7:0] want;
    } vec_t;

    logic clk;
    logic rst_n;

    pipelined_barrel_rotator_if #(.N(N)) bus ();

    pipelined_barrel_rotator #(
        .N (N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    logic       chk_lat = 1'b0;
    logic [7:0] next_exp = '0;
    logic [7:0] exp_q[$];
    int         cyc_q[$];

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, want, $time);
        end
    endtask

    task automatic chki(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [7:0] rot_model(input logic [7:0] d, input logic [2:0] a,
                                             input logic right);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            int j;
            j = (i + int'(a)) % 8;
            if (right) r[i] = d[j];
            else       r[j] = d[i];
        end
        return r;
    endfunction

    // Monitor: both sides are sampled mid-cycle, ahead of the edge that transfers.
    always @(negedge clk) begin
        if (rst_n) begin
            cyc++;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chki("unexpected_output", 1, 0);
                end else begin
                    logic [7:0] w;
                    int         t;
                    w = exp_q.pop_front();
                    t = cyc_q.pop_front();
                    chk8("out_data", bus.out_data, w);
                    if (chk_lat) chki("latency", cyc - t, SW);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(next_exp);
                cyc_q.push_back(cyc);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the word.
    task automatic send(input logic [7:0] d, input logic [2:0] a, input logic right,
                        input logic [7:0] want);
        logic took;
        took         = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_amt   = a;
        bus.in_dir   = right;
        next_exp     = want;
        for (int i = 0; i < 100 && !took; i++) begin
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk);
            #1;
        end
        if (!took) chki("send_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chki("drain_empty", exp_q.size(), 0);
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{8'hB4, 3'd3, 1'b1, 8'h96};
        vecs[1]  = '{8'hB4, 3'd3, 1'b0, 8'hA5};
        vecs[2]  = '{8'hB4, 3'd5, 1'b0, 8'h96};
        vecs[3]  = '{8'hB4, 3'd0, 1'b0, 8'hB4};
        vecs[4]  = '{8'hB4, 3'd0, 1'b1, 8'hB4};
        vecs[5]  = '{8'hB4, 3'd7, 1'b0, 8'h5A};
        vecs[6]  = '{8'hB4, 3'd7, 1'b1, 8'h69};
        vecs[7]  = '{8'h01, 3'd1, 1'b0, 8'h02};
        vecs[8]  = '{8'h80, 3'd1, 1'b0, 8'h01};
        vecs[9]  = '{8'h01, 3'd1, 1'b1, 8'h80};
        vecs[10] = '{8'hC3, 3'd4, 1'b1, 8'h3C};

        clk           = 1'b0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_amt    = '0;
        bus.in_dir    = 1'b0;
        bus.out_ready = 1'b1;

        #1;
        chki("reset_out_valid", int'(bus.out_valid), 0);
        chk8("reset_out_data", bus.out_data, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chki("reset_in_ready", int'(bus.in_ready), 1);

        // Directed table, issued back to back with latency checking.
        chk_lat = 1'b1;
        foreach (vecs[i]) send(vecs[i].data, vecs[i].amt, vecs[i].dir, vecs[i].want);
        drain();

        // 16 random words streamed at full rate.
        for (int i = 0; i < 16; i++) begin
            logic [7:0] d;
            logic [2:0] a;
            logic       r;
            d = 8'($urandom);
            a = 3'($urandom_range(0, 7));
            r = 1'($urandom_range(0, 1));
            send(d, a, r, rot_model(d, a, r));
        end
        drain();
        chk_lat = 1'b0;

        // Stall: consumer blocked for 10 cycles with the producer always offering.
        begin
            int         acc;
            logic       took;
            logic       have_ref;
            logic [7:0] ref_d;
            int         unstable;
            acc           = 0;
            took          = 1'b1;
            have_ref      = 1'b0;
            ref_d         = '0;
            unstable      = 0;
            bus.out_ready = 1'b0;
            for (int i = 0; i < 10; i++) begin
                if (took) begin
                    bus.in_valid = 1'b1;
                    bus.in_data  = 8'($urandom);
                    bus.in_amt   = 3'($urandom_range(0, 7));
                    bus.in_dir   = 1'($urandom_range(0, 1));
                    next_exp     = rot_model(bus.in_data, bus.in_amt, bus.in_dir);
                end
                @(negedge clk);
                took = bus.in_ready;
                if (took) acc++;
                if (bus.out_valid) begin
                    if (!have_ref) begin
                        ref_d    = bus.out_data;
                        have_ref = 1'b1;
                    end else if (bus.out_data !== ref_d) begin
                        unstable++;
                    end
                end
                @(posedge clk);
                #1;
            end
            chki("stall_accepts", acc, SW);
            chki("stall_in_ready", int'(bus.in_ready), 0);
            chki("stall_out_valid", int'(bus.out_valid), 1);
            chki("stall_unstable", unstable, 0);
            chk8("stall_hold", bus.out_data, ref_d);
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            drain();
        end

        // Random valid/ready for 1000 cycles; held words stay unchanged until accepted.
        begin
            logic took;
            took = 1'b1;
            for (int i = 0; i < 1000; i++) begin
                if (!bus.in_valid || took) begin
                    bus.in_valid = 1'($urandom_range(0, 1));
                    bus.in_data  = 8'($urandom);
                    bus.in_amt   = 3'($urandom_range(0, 7));
                    bus.in_dir   = 1'($urandom_range(0, 1));
                    next_exp     = rot_model(bus.in_data, bus.in_amt, bus.in_dir);
                end
                bus.out_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                took = bus.in_valid && bus.in_ready;
                @(posedge clk);
                #1;
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
            drain();
        end

        // Mid-stream asynchronous reset with two words in flight.
        bus.out_ready = 1'b0;
        send(8'h11, 3'd1, 1'b0, 8'h22);
        send(8'h44, 3'd2, 1'b1, 8'h11);
        @(posedge clk);
        #1;
        chki("inflight_out_valid", int'(bus.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chki("async_rst_out_valid", int'(bus.out_valid), 0);
        chk8("async_rst_out_data", bus.out_data, 8'h00);
        exp_q.delete();
        cyc_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chki("post_rst_in_ready", int'(bus.in_ready), 1);
        chki("post_rst_out_valid", int'(bus.out_valid), 0);
        bus.out_ready = 1'b1;
        send(8'h3C, 3'd2, 1'b0, 8'hF0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
